// File: rtl/decode_issue_stage.sv
// Decode/issue stage for an RV64I-style pipeline.
// It decodes the incoming instruction, reads the register file (with same-cycle
// writeback forwarding), detects load-use hazards against the instruction in its
// output register, and holds the decoded fields in a valid/ready output register.

// Immediate generator: selects the immediate of the instruction format and
// sign-extends it to the datapath width.
module extend_imm #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:7]           instr_hi,
  input  logic [2:0]            imm_src,
  output logic [DATA_WIDTH-1:0] imm_ext
);

  // Assemble the I/S/B/U/J immediate from the instruction bits
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      3'b000:  imm_ext = {{(DATA_WIDTH-12){instr_hi[31]}}, instr_hi[31:20]};
      3'b001:  imm_ext = {{(DATA_WIDTH-12){instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      3'b010:  imm_ext = {{(DATA_WIDTH-12){instr_hi[31]}}, instr_hi[7], instr_hi[30:25],
                          instr_hi[11:8], 1'b0};
      3'b011:  imm_ext = {{(DATA_WIDTH-32){instr_hi[31]}}, instr_hi[31:12], 12'b0};
      3'b100:  imm_ext = {{(DATA_WIDTH-20){instr_hi[31]}}, instr_hi[19:12], instr_hi[20],
                          instr_hi[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

endmodule

// Main decoder: turns opcode/funct fields into datapath control signals.
module control_unit #(
  parameter logic [2:0] LOAD_SRC = 3'b001
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic       reg_we,
  output logic       mem_we,
  output logic       alu_src,
  output logic       branch,
  output logic       jump,
  output logic [2:0] result_src,
  output logic [2:0] imm_src,
  output logic [4:0] alu_control
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_IW     = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] SRC_ALU   = 3'b000;
  localparam logic [2:0] SRC_PC4   = 3'b010;
  localparam logic [2:0] SRC_PCIMM = 3'b011;

  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_PASSB = 5'b01010;

  // Base ALU operation for a funct3; alt selects sub/sra. Bit 4 of the
  // final code marks 32-bit word operations.
  function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_base = alt ? 4'd1 : 4'd0;
      3'b001:  alu_base = 4'd2;
      3'b010:  alu_base = 4'd3;
      3'b011:  alu_base = 4'd4;
      3'b100:  alu_base = 4'd5;
      3'b101:  alu_base = alt ? 4'd7 : 4'd6;
      3'b110:  alu_base = 4'd8;
      default: alu_base = 4'd9;
    endcase
  endfunction

  // Decode the opcode into control signals; unknown opcodes decode as a no-op
  always_comb begin
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    alu_src     = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    result_src  = SRC_ALU;
    imm_src     = IMM_I;
    alu_control = 5'b00000;
    case (opcode)
      OP_R: begin
        reg_we      = 1'b1;
        alu_control = {1'b0, alu_base(funct3, funct7_b5)};
      end
      OP_RW: begin
        reg_we      = 1'b1;
        alu_control = {1'b1, alu_base(funct3, funct7_b5)};
      end
      OP_I: begin
        reg_we      = 1'b1;
        alu_src     = 1'b1;
        alu_control = {1'b0, alu_base(funct3, (funct3 == 3'b101) & funct7_b5)};
      end
      OP_IW: begin
        reg_we      = 1'b1;
        alu_src     = 1'b1;
        alu_control = {1'b1, alu_base(funct3, (funct3 == 3'b101) & funct7_b5)};
      end
      OP_LOAD: begin
        reg_we     = 1'b1;
        alu_src    = 1'b1;
        result_src = LOAD_SRC;
      end
      OP_STORE: begin
        mem_we  = 1'b1;
        alu_src = 1'b1;
        imm_src = IMM_S;
      end
      OP_BRANCH: begin
        branch      = 1'b1;
        imm_src     = IMM_B;
        alu_control = ALU_SUB;
      end
      OP_JAL: begin
        reg_we     = 1'b1;
        jump       = 1'b1;
        imm_src    = IMM_J;
        result_src = SRC_PC4;
      end
      OP_JALR: begin
        reg_we     = 1'b1;
        jump       = 1'b1;
        alu_src    = 1'b1;
        result_src = SRC_PC4;
      end
      OP_LUI: begin
        reg_we      = 1'b1;
        alu_src     = 1'b1;
        imm_src     = IMM_U;
        alu_control = ALU_PASSB;
      end
      OP_AUIPC: begin
        reg_we     = 1'b1;
        alu_src    = 1'b1;
        imm_src    = IMM_U;
        result_src = SRC_PCIMM;
      end
      default: ;
    endcase
  end

endmodule

// Decode/issue stage top level.
module decode_issue_stage #(
  parameter int         ADDR_WIDTH  = 64,
  parameter int         DATA_WIDTH  = 64,
  parameter int         REG_ADDR_W  = 5,
  parameter int         INSTR_WIDTH = 32,
  parameter logic [2:0] LOAD_SRC    = 3'b001,
  parameter int         STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [INSTR_WIDTH-1:0] i_instruction,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic [ADDR_WIDTH-1:0]  i_pc_plus4,
  input  logic                   i_reg_we,
  input  logic [REG_ADDR_W-1:0]  i_rd_addr,
  input  logic [DATA_WIDTH-1:0]  i_rd_write_data,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic [DATA_WIDTH-1:0]  o_rs1_data,
  output logic [DATA_WIDTH-1:0]  o_rs2_data,
  output logic [DATA_WIDTH-1:0]  o_imm_ext,
  output logic [REG_ADDR_W-1:0]  o_rs1_addr,
  output logic [REG_ADDR_W-1:0]  o_rs2_addr,
  output logic [REG_ADDR_W-1:0]  o_rd_addr,
  output logic [2:0]             o_func3,
  output logic [2:0]             o_result_src,
  output logic [4:0]             o_alu_control,
  output logic                   o_mem_we,
  output logic                   o_reg_we,
  output logic                   o_alu_src,
  output logic                   o_branch,
  output logic                   o_jump,
  output logic                   o_load_use_stall,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic [2:0]            func3;
  logic                  dec_reg_we;
  logic                  dec_mem_we;
  logic                  dec_alu_src;
  logic                  dec_branch;
  logic                  dec_jump;
  logic [2:0]            dec_result_src;
  logic [2:0]            dec_imm_src;
  logic [4:0]            dec_alu_control;
  logic [DATA_WIDTH-1:0] dec_imm_ext;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  hazard;
  logic                  advance;
  logic                  accept;

  assign rs1   = i_instruction[15 +: REG_ADDR_W];
  assign rs2   = i_instruction[20 +: REG_ADDR_W];
  assign rd    = i_instruction[7 +: REG_ADDR_W];
  assign func3 = i_instruction[14:12];

  control_unit #(
    .LOAD_SRC(LOAD_SRC)
  ) u_control (
    .opcode     (i_instruction[6:0]),
    .funct3     (func3),
    .funct7_b5  (i_instruction[30]),
    .reg_we     (dec_reg_we),
    .mem_we     (dec_mem_we),
    .alu_src    (dec_alu_src),
    .branch     (dec_branch),
    .jump       (dec_jump),
    .result_src (dec_result_src),
    .imm_src    (dec_imm_src),
    .alu_control(dec_alu_control)
  );

  extend_imm #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extend (
    .instr_hi(i_instruction[31:7]),
    .imm_src (dec_imm_src),
    .imm_ext (dec_imm_ext)
  );

  // Register file write port; x0 is never written so it always reads as zero
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (i_reg_we && (i_rd_addr != '0)) begin
      regs[i_rd_addr] <= i_rd_write_data;
    end
  end

  // Read ports forward a same-cycle writeback so the issued operand is current
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != '0) rs1_data = (i_reg_we && (i_rd_addr == rs1)) ? i_rd_write_data : regs[rs1];
    if (rs2 != '0) rs2_data = (i_reg_we && (i_rd_addr == rs2)) ? i_rd_write_data : regs[rs2];
  end

  // A load sitting in the output register cannot feed the next instruction yet
  assign hazard = o_valid & i_valid & (o_result_src == LOAD_SRC) & (o_rd_addr != '0) &
                  ((o_rd_addr == rs1) | (o_rd_addr == rs2));
  assign o_load_use_stall = hazard;
  assign advance = !o_valid | i_ready;
  assign o_ready = advance & !hazard & !i_flush;
  assign accept  = i_valid & o_ready;

  // Output register: flush beats accept, accept beats bubble, otherwise hold
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_valid       <= 1'b0;
      o_pc          <= '0;
      o_pc_plus4    <= '0;
      o_rs1_data    <= '0;
      o_rs2_data    <= '0;
      o_imm_ext     <= '0;
      o_rs1_addr    <= '0;
      o_rs2_addr    <= '0;
      o_rd_addr     <= '0;
      o_func3       <= '0;
      o_result_src  <= '0;
      o_alu_control <= '0;
      o_mem_we      <= 1'b0;
      o_reg_we      <= 1'b0;
      o_alu_src     <= 1'b0;
      o_branch      <= 1'b0;
      o_jump        <= 1'b0;
    end else if (i_flush || (!accept && advance)) begin
      o_valid  <= 1'b0;
      o_reg_we <= 1'b0;
      o_mem_we <= 1'b0;
      o_branch <= 1'b0;
      o_jump   <= 1'b0;
    end else if (accept) begin
      o_valid       <= 1'b1;
      o_pc          <= i_pc;
      o_pc_plus4    <= i_pc_plus4;
      o_rs1_data    <= rs1_data;
      o_rs2_data    <= rs2_data;
      o_imm_ext     <= dec_imm_ext;
      o_rs1_addr    <= rs1;
      o_rs2_addr    <= rs2;
      o_rd_addr     <= rd;
      o_func3       <= func3;
      o_result_src  <= dec_result_src;
      o_alu_control <= dec_alu_control;
      o_mem_we      <= dec_mem_we;
      o_reg_we      <= dec_reg_we;
      o_alu_src     <= dec_alu_src;
      o_branch      <= dec_branch;
      o_jump        <= dec_jump;
    end
  end

  // Count load-use stall cycles, saturating so the counter never wraps
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_stall_cnt <= '0;
    end else if (hazard && !i_flush && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed testbench for decode_issue_stage: reset, issue, load-use stall,
// register-file forwarding, hold/flush, stall-counter saturation, async reset.
module tb_decode_issue_stage;

  localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] LW_X2_X1    = 32'h0000A103;
  localparam logic [31:0] ADD_X3      = 32'h001101B3;
  localparam logic [31:0] ADDI_X6_X5  = 32'h00028313;
  localparam logic [31:0] ADD_X8_X5X5 = 32'h00528433;
  localparam logic [31:0] ADDI_X7_X0  = 32'h00000393;
  localparam logic [31:0] ADDI_X9_7   = 32'h00700493;

  logic        i_clk;
  logic        i_arst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instruction;
  logic [63:0] i_pc;
  logic [63:0] i_pc_plus4;
  logic        i_reg_we;
  logic [4:0]  i_rd_addr;
  logic [63:0] i_rd_write_data;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_pc;
  logic [63:0] o_pc_plus4;
  logic [63:0] o_rs1_data;
  logic [63:0] o_rs2_data;
  logic [63:0] o_imm_ext;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [4:0]  o_rd_addr;
  logic [2:0]  o_func3;
  logic [2:0]  o_result_src;
  logic [4:0]  o_alu_control;
  logic        o_mem_we;
  logic        o_reg_we;
  logic        o_alu_src;
  logic        o_branch;
  logic        o_jump;
  logic        o_load_use_stall;
  logic [1:0]  o_stall_cnt;

  int errors = 0;
  int checks = 0;

  decode_issue_stage #(
    .STALL_CNT_W(2)
  ) dut (
    .i_clk           (i_clk),
    .i_arst_n        (i_arst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_instruction   (i_instruction),
    .i_pc            (i_pc),
    .i_pc_plus4      (i_pc_plus4),
    .i_reg_we        (i_reg_we),
    .i_rd_addr       (i_rd_addr),
    .i_rd_write_data (i_rd_write_data),
    .i_flush         (i_flush),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_pc            (o_pc),
    .o_pc_plus4      (o_pc_plus4),
    .o_rs1_data      (o_rs1_data),
    .o_rs2_data      (o_rs2_data),
    .o_imm_ext       (o_imm_ext),
    .o_rs1_addr      (o_rs1_addr),
    .o_rs2_addr      (o_rs2_addr),
    .o_rd_addr       (o_rd_addr),
    .o_func3         (o_func3),
    .o_result_src    (o_result_src),
    .o_alu_control   (o_alu_control),
    .o_mem_we        (o_mem_we),
    .o_reg_we        (o_reg_we),
    .o_alu_src       (o_alu_src),
    .o_branch        (o_branch),
    .o_jump          (o_jump),
    .o_load_use_stall(o_load_use_stall),
    .o_stall_cnt     (o_stall_cnt)
  );

  // Free-running 10 ns clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Guard against a stuck simulation
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [63:0] pc);
    i_valid       = valid;
    i_instruction = instr;
    i_pc          = pc;
    i_pc_plus4    = pc + 64'd4;
  endtask

  task automatic test_reset;
    i_arst_n = 1'b0;
    tick;
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", o_valid); end
    checks++; if (o_stall_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0h expected 0", o_stall_cnt); end
    checks++; if (o_rd_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd_addr: got %0h expected 0", o_rd_addr); end
    checks++; if (o_imm_ext !== 64'd0) begin errors++; $display("[TB] FAIL reset_imm: got %0h expected 0", o_imm_ext); end
    checks++; if (o_reg_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_reg_we: got %0h expected 0", o_reg_we); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0h expected 1", o_ready); end
    i_arst_n = 1'b1;
  endtask

  task automatic test_basic_issue;
    applyStimulus(1'b1, ADDI_X1_5, 64'h100);
    tick;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL issue_valid: got %0h expected 1", o_valid); end
    checks++; if (o_rd_addr !== 5'd1) begin errors++; $display("[TB] FAIL issue_rd: got %0h expected 1", o_rd_addr); end
    checks++; if (o_imm_ext !== 64'd5) begin errors++; $display("[TB] FAIL issue_imm: got %0h expected 5", o_imm_ext); end
    checks++; if (o_reg_we !== 1'b1) begin errors++; $display("[TB] FAIL issue_reg_we: got %0h expected 1", o_reg_we); end
    checks++; if (o_alu_src !== 1'b1) begin errors++; $display("[TB] FAIL issue_alu_src: got %0h expected 1", o_alu_src); end
    checks++; if (o_pc !== 64'h100) begin errors++; $display("[TB] FAIL issue_pc: got %0h expected 100", o_pc); end
    checks++; if (o_pc_plus4 !== 64'h104) begin errors++; $display("[TB] FAIL issue_pc4: got %0h expected 104", o_pc_plus4); end
    checks++; if (o_result_src !== 3'b000) begin errors++; $display("[TB] FAIL issue_result_src: got %0h expected 0", o_result_src); end
    applyStimulus(1'b0, 32'h0, 64'h0);
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bubble_valid: got %0h expected 0", o_valid); end
    checks++; if (o_reg_we !== 1'b0) begin errors++; $display("[TB] FAIL bubble_reg_we: got %0h expected 0", o_reg_we); end
  endtask

  task automatic test_load_use;
    applyStimulus(1'b1, LW_X2_X1, 64'h200);
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL lw_ready: got %0h expected 1", o_ready); end
    tick;
    checks++; if (o_result_src !== 3'b001) begin errors++; $display("[TB] FAIL lw_result_src: got %0h expected 1", o_result_src); end
    checks++; if (o_func3 !== 3'b010) begin errors++; $display("[TB] FAIL lw_func3: got %0h expected 2", o_func3); end
    checks++; if (o_rd_addr !== 5'd2) begin errors++; $display("[TB] FAIL lw_rd: got %0h expected 2", o_rd_addr); end
    applyStimulus(1'b1, ADD_X3, 64'h204);
    #1;
    checks++; if (o_load_use_stall !== 1'b1) begin errors++; $display("[TB] FAIL hazard_stall: got %0h expected 1", o_load_use_stall); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_ready: got %0h expected 0", o_ready); end
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL hazard_bubble: got %0h expected 0", o_valid); end
    checks++; if (o_stall_cnt !== 2'd1) begin errors++; $display("[TB] FAIL hazard_cnt: got %0h expected 1", o_stall_cnt); end
    checks++; if (o_load_use_stall !== 1'b0) begin errors++; $display("[TB] FAIL hazard_cleared: got %0h expected 0", o_load_use_stall); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL hazard_ready_again: got %0h expected 1", o_ready); end
    tick;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %0h expected 1", o_valid); end
    checks++; if (o_rd_addr !== 5'd3) begin errors++; $display("[TB] FAIL add_rd: got %0h expected 3", o_rd_addr); end
    checks++; if (o_rs1_addr !== 5'd2) begin errors++; $display("[TB] FAIL add_rs1: got %0h expected 2", o_rs1_addr); end
    checks++; if (o_rs2_addr !== 5'd1) begin errors++; $display("[TB] FAIL add_rs2: got %0h expected 1", o_rs2_addr); end
    checks++; if (o_stall_cnt !== 2'd1) begin errors++; $display("[TB] FAIL add_cnt: got %0h expected 1", o_stall_cnt); end
    applyStimulus(1'b0, 32'h0, 64'h0);
  endtask

  task automatic test_regfile_bypass;
    i_reg_we        = 1'b1;
    i_rd_addr       = 5'd5;
    i_rd_write_data = 64'hDEAD;
    applyStimulus(1'b1, ADDI_X6_X5, 64'h300);
    tick;
    checks++; if (o_rs1_data !== 64'hDEAD) begin errors++; $display("[TB] FAIL bypass_rs1: got %0h expected dead", o_rs1_data); end
    i_reg_we = 1'b0;
    applyStimulus(1'b1, ADD_X8_X5X5, 64'h304);
    tick;
    checks++; if (o_rs1_data !== 64'hDEAD) begin errors++; $display("[TB] FAIL stored_rs1: got %0h expected dead", o_rs1_data); end
    checks++; if (o_rs2_data !== 64'hDEAD) begin errors++; $display("[TB] FAIL stored_rs2: got %0h expected dead", o_rs2_data); end
    i_reg_we        = 1'b1;
    i_rd_addr       = 5'd0;
    i_rd_write_data = 64'h1234;
    applyStimulus(1'b1, ADDI_X7_X0, 64'h308);
    tick;
    checks++; if (o_rs1_data !== 64'd0) begin errors++; $display("[TB] FAIL x0_bypass: got %0h expected 0", o_rs1_data); end
    i_reg_we = 1'b0;
    applyStimulus(1'b1, ADDI_X7_X0, 64'h30C);
    tick;
    checks++; if (o_rs1_data !== 64'd0) begin errors++; $display("[TB] FAIL x0_read: got %0h expected 0", o_rs1_data); end
    applyStimulus(1'b0, 32'h0, 64'h0);
  endtask

  task automatic test_hold_and_flush;
    i_ready = 1'b1;
    applyStimulus(1'b1, ADDI_X1_5, 64'h400);
    tick;
    i_ready = 1'b0;
    applyStimulus(1'b1, ADDI_X9_7, 64'h404);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready: got %0h expected 0", o_ready); end
      tick;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: got %0h expected 1", o_valid); end
      checks++; if (o_rd_addr !== 5'd1) begin errors++; $display("[TB] FAIL hold_rd: got %0h expected 1", o_rd_addr); end
      checks++; if (o_pc !== 64'h400) begin errors++; $display("[TB] FAIL hold_pc: got %0h expected 400", o_pc); end
    end
    i_ready = 1'b1;
    i_flush = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %0h expected 0", o_ready); end
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %0h expected 0", o_valid); end
    checks++; if (o_reg_we !== 1'b0) begin errors++; $display("[TB] FAIL flush_reg_we: got %0h expected 0", o_reg_we); end
    i_flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 64'h0);
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_not_issued: got %0h expected 0", o_valid); end
    checks++; if (o_rd_addr === 5'd9) begin errors++; $display("[TB] FAIL flush_dropped_rd: got %0h expected not 9", o_rd_addr); end
  endtask

  task automatic test_stall_saturation;
    i_arst_n = 1'b0;
    #2;
    i_arst_n = 1'b1;
    i_ready  = 1'b1;
    applyStimulus(1'b1, LW_X2_X1, 64'h500);
    tick;
    checks++; if (o_stall_cnt !== 2'd0) begin errors++; $display("[TB] FAIL sat_start: got %0h expected 0", o_stall_cnt); end
    i_ready = 1'b0;
    applyStimulus(1'b1, ADD_X3, 64'h504);
    tick;
    tick;
    checks++; if (o_stall_cnt !== 2'd2) begin errors++; $display("[TB] FAIL sat_two: got %0h expected 2", o_stall_cnt); end
    tick;
    tick;
    tick;
    checks++; if (o_stall_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_five: got %0h expected 3", o_stall_cnt); end
    checks++; if (o_load_use_stall !== 1'b1) begin errors++; $display("[TB] FAIL sat_still_stall: got %0h expected 1", o_load_use_stall); end
  endtask

  task automatic test_async_reset;
    #3;
    i_arst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %0h expected 0", o_valid); end
    checks++; if (o_stall_cnt !== 2'd0) begin errors++; $display("[TB] FAIL arst_cnt: got %0h expected 0", o_stall_cnt); end
    checks++; if (o_load_use_stall !== 1'b0) begin errors++; $display("[TB] FAIL arst_stall: got %0h expected 0", o_load_use_stall); end
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_held: got %0h expected 0", o_valid); end
    i_arst_n = 1'b1;
    i_ready  = 1'b1;
    applyStimulus(1'b1, ADDI_X6_X5, 64'h600);
    tick;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_first_accept: got %0h expected 1", o_valid); end
    checks++; if (o_rs1_data !== 64'd0) begin errors++; $display("[TB] FAIL arst_regfile: got %0h expected 0", o_rs1_data); end
  endtask

  // Run every scenario in order and report
  initial begin
    i_arst_n        = 1'b0;
    i_valid         = 1'b0;
    i_instruction   = 32'h0;
    i_pc            = 64'h0;
    i_pc_plus4      = 64'h0;
    i_reg_we        = 1'b0;
    i_rd_addr       = 5'd0;
    i_rd_write_data = 64'h0;
    i_flush         = 1'b0;
    i_ready         = 1'b1;
    test_reset;
    test_basic_issue;
    test_load_use;
    test_regfile_bypass;
    test_hold_and_flush;
    test_stall_saturation;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, program counter width.
REQ-002 Parameter DATA_WIDTH, default 64, register and immediate width.
REQ-003 Parameter REG_ADDR_W, default 5, register address width; register count is 2**REG_ADDR_W.
REQ-004 Parameter INSTR_WIDTH, default 32, instruction width.
REQ-005 Parameter LOAD_SRC, default 3'b001, result_src code marking a memory load.
REQ-006 Parameter STALL_CNT_W, default 16, stall counter width.
REQ-007 Ports: i_clk in 1 clock; i_arst_n in 1 reset, asynchronous, active-low.
REQ-008 Upstream: i_valid in 1; o_ready out 1; i_instruction in INSTR_WIDTH; i_pc, i_pc_plus4 in ADDR_WIDTH each.
REQ-009 Writeback: i_reg_we in 1; i_rd_addr in REG_ADDR_W; i_rd_write_data in DATA_WIDTH.
REQ-010 Control: i_flush in 1, drops the held instruction.
REQ-011 Downstream: o_valid out 1; i_ready in 1.
REQ-012 Registered outputs: o_pc, o_pc_plus4 (ADDR_WIDTH); o_rs1_data, o_rs2_data, o_imm_ext (DATA_WIDTH); o_rs1_addr, o_rs2_addr, o_rd_addr (REG_ADDR_W); o_func3 (3); o_result_src (3); o_alu_control (5); o_mem_we, o_reg_we, o_alu_src, o_branch, o_jump (1 each).
REQ-013 Status: o_load_use_stall out 1, combinational; o_stall_cnt out STALL_CNT_W.

Function
REQ-014 The block SHALL decode through the existing control_unit and extend_imm, using the standard RV field slices.
REQ-015 The register file SHALL hold 2**REG_ADDR_W entries, be written on the rising edge when i_reg_we=1 and i_rd_addr!=0, and read x0 as 0.
REQ-016 A read SHALL return i_rd_write_data when i_reg_we=1, i_rd_addr equals the read address, and the read address is not 0.
REQ-017 hazard SHALL be o_valid & i_valid & (o_result_src==LOAD_SRC) & (o_rd_addr!=0) & (o_rd_addr==rs1 | o_rd_addr==rs2).
REQ-018 o_load_use_stall SHALL equal hazard.
REQ-019 advance SHALL be !o_valid | i_ready.
REQ-020 o_ready SHALL be advance & !hazard & !i_flush.
REQ-021 On an edge with i_flush=1, o_valid SHALL become 0 and o_reg_we, o_mem_we, o_branch, o_jump SHALL become 0. Flush has priority over all other actions.
REQ-022 Otherwise, on an edge with i_valid & o_ready, all outputs SHALL load the decoded instruction and o_valid SHALL become 1. Latency is one cycle.
REQ-023 Otherwise, when advance=1 (no accept, or hazard), the block SHALL insert a bubble: o_valid=0, and o_reg_we, o_mem_we, o_branch, o_jump=0.
REQ-024 Otherwise (o_valid=1, i_ready=0), all outputs SHALL hold.
REQ-025 While o_valid=0, o_reg_we, o_mem_we, o_branch and o_jump SHALL be 0.
REQ-026 o_stall_cnt SHALL increment on each edge with hazard=1 and i_flush=0, and SHALL saturate at all-ones.
REQ-027 A hazard SHALL clear after exactly one bubble when i_ready=1, because the load leaves the output register.

Reset
REQ-028 While i_arst_n=0, all output registers and o_stall_cnt SHALL be 0, o_valid SHALL be 0, and all register-file entries SHALL be 0.
REQ-029 Reset SHALL take effect immediately, including mid-stall or mid-transfer. After release, the first accept SHALL occur on the first edge with i_valid=1.

Verification
REQ-030 Reset, then i_valid=1, i_ready=1, instruction 0x00500093 (addi x1,x0,5). Required response next cycle: o_valid=1, o_rd_addr=1, o_imm_ext=5, o_reg_we=1, o_alu_src=1.
REQ-031 Issue 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) back-to-back with i_ready=1. Required response: in the add's first cycle o_load_use_stall=1 and o_ready=0; then one bubble (o_valid=0); the add issues one cycle later; o_stall_cnt=1.
REQ-032 Write x5=0xDEAD with i_reg_we=1 in the same cycle an instruction reading x5 is accepted. Required response: o_rs1_data=0xDEAD. A write to x0 with data 0x1234 SHALL still read back 0.
REQ-033 Hold i_ready=0 for 3 cycles with o_valid=1. Required response: outputs stable and o_ready=0. Then assert i_flush=1 for one cycle with i_valid=1. Required response: o_valid=0 next cycle, o_ready=0 during the flush, and the incoming instruction is not issued.
REQ-034 With STALL_CNT_W=2, force 5 hazard cycles. Required response: o_stall_cnt=3.
REQ-035 Assert i_arst_n=0 mid-hazard. Required response: o_valid=0, o_stall_cnt=0, and o_load_use_stall=0 immediately.
